// File: rtl/lsu_ctrl.sv
// Load/store controller: one core request at a time, word-wide big-endian data memory,
// read-modify-write for sub-word stores. Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word.
module lsu_ctrl #(
    parameter logic [31:0] ADDR_LIMIT = 32'd256
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_signed,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_resp_valid,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_err,
    output logic        o_dm_we,
    output logic [31:0] o_dm_addr,
    output logic [31:0] o_dm_wdata,
    input  logic [31:0] i_dm_rdata
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    logic [1:0]  state_q,    state_d;
    logic        we_q,       we_d;
    logic [1:0]  size_q,     size_d;
    logic        signed_q,   signed_d;
    logic [1:0]  off_q,      off_d;
    logic [31:0] wdata_q,    wdata_d;
    logic [31:0] dm_addr_q,  dm_addr_d;
    logic [31:0] dm_wdata_q, dm_wdata_d;
    logic [31:0] rdata_q,    rdata_d;
    logic        err_q,      err_d;

    logic        accept_s;
    logic        size_bad_s;
    logic        range_bad_s;
    logic        misalign_s;
    logic        req_err_s;
    logic [1:0]  req_off_s;

    // Insert right-aligned store data into the addressed big-endian lane of a word.
    function automatic logic [31:0] merge_word(
        input logic [31:0] word,
        input logic [31:0] data,
        input logic [1:0]  size,
        input logic [1:0]  off
    );
        logic [31:0] res;
        res = word;
        case (size)
            SZ_BYTE: begin
                case (off)
                    2'd0:    res[31:24] = data[7:0];
                    2'd1:    res[23:16] = data[7:0];
                    2'd2:    res[15:8]  = data[7:0];
                    default: res[7:0]   = data[7:0];
                endcase
            end
            SZ_HALF: begin
                if (off[1]) begin
                    res[15:0] = data[15:0];
                end else begin
                    res[31:16] = data[15:0];
                end
            end
            default: res = data;
        endcase
        return res;
    endfunction

    // Pull the addressed lane out of a word, right-align it and extend it.
    function automatic logic [31:0] extract_load(
        input logic [31:0] word,
        input logic [1:0]  size,
        input logic [1:0]  off,
        input logic        sgn
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (off)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        h = off[1] ? word[15:0] : word[31:16];
        case (size)
            SZ_BYTE: res = sgn ? {{24{b[7]}}, b} : {24'h000000, b};
            SZ_HALF: res = sgn ? {{16{h[15]}}, h} : {16'h0000, h};
            default: res = word;
        endcase
        return res;
    endfunction

    // Request classification at accept: errors and effective lane offset.
    always_comb begin
        accept_s    = i_req_valid && (state_q == ST_IDLE);
        size_bad_s  = (i_req_size == 2'b11);
        range_bad_s = ({i_req_addr[31:2], 2'b11} >= ADDR_LIMIT);
        misalign_s  = 1'b0;
        req_off_s   = i_req_addr[1:0];
`ifdef LSU_MISALIGN_TRAP_EN
        if (i_req_size == SZ_HALF) begin
            misalign_s = i_req_addr[0];
        end else if (i_req_size == SZ_WORD) begin
            misalign_s = (i_req_addr[1:0] != 2'b00);
        end else begin
            misalign_s = 1'b0;
        end
`else
        // Without trapping, offending low bits are simply dropped.
        case (i_req_size)
            SZ_HALF: req_off_s = {i_req_addr[1], 1'b0};
            SZ_WORD: req_off_s = 2'b00;
            default: req_off_s = i_req_addr[1:0];
        endcase
`endif
        req_err_s = size_bad_s || range_bad_s || misalign_s;
    end

    // Next-state and datapath register update.
    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        size_d     = size_q;
        signed_d   = signed_q;
        off_d      = off_q;
        wdata_d    = wdata_q;
        dm_addr_d  = dm_addr_q;
        dm_wdata_d = dm_wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    we_d      = i_req_we;
                    size_d    = i_req_size;
                    signed_d  = i_req_signed;
                    off_d     = req_off_s;
                    wdata_d   = i_req_wdata;
                    dm_addr_d = {i_req_addr[31:2], 2'b00};
                    rdata_d   = 32'h0000_0000;
                    err_d     = req_err_s;
                    if (req_err_s) begin
                        state_d = ST_DONE;
                    end else if (i_req_we && (i_req_size == SZ_WORD)) begin
                        dm_wdata_d = i_req_wdata;
                        state_d    = ST_WR;
                    end else begin
                        state_d = ST_RD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD: begin
                if (we_q) begin
                    dm_wdata_d = merge_word(i_dm_rdata, wdata_q, size_q, off_q);
                    state_d    = ST_WR;
                end else begin
                    rdata_d = extract_load(i_dm_rdata, size_q, off_q, signed_q);
                    state_d = ST_DONE;
                end
            end
            ST_WR: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                rdata_d = 32'h0000_0000;
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and captured-request registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            we_q       <= 1'b0;
            size_q     <= 2'b00;
            signed_q   <= 1'b0;
            off_q      <= 2'b00;
            wdata_q    <= 32'h0000_0000;
            dm_addr_q  <= 32'h0000_0000;
            dm_wdata_q <= 32'h0000_0000;
            rdata_q    <= 32'h0000_0000;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            size_q     <= size_d;
            signed_q   <= signed_d;
            off_q      <= off_d;
            wdata_q    <= wdata_d;
            dm_addr_q  <= dm_addr_d;
            dm_wdata_q <= dm_wdata_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    assign o_req_ready  = (state_q == ST_IDLE);
    assign o_resp_valid = (state_q == ST_DONE);
    assign o_resp_rdata = rdata_q;
    assign o_resp_err   = err_q;
    assign o_dm_we      = (state_q == ST_WR);
    assign o_dm_addr    = dm_addr_q;
    assign o_dm_wdata   = dm_wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed table-driven bench for lsu_ctrl with a small word-memory model.
module tb_lsu_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;

    logic [31:0] mem [0:63];
    logic        mem_init;

    int total;
    int bad;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic        err;
        logic [31:0] rdata;
        logic [31:0] mwdata;
    } vec_t;

    localparam int NV = 26;
    vec_t vtab [0:NV-1];

    lsu_ctrl dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_we     (req_we),
        .i_req_size   (req_size),
        .i_req_signed (req_signed),
        .i_req_addr   (req_addr),
        .i_req_wdata  (req_wdata),
        .o_resp_valid (resp_valid),
        .o_resp_rdata (resp_rdata),
        .o_resp_err   (resp_err),
        .o_dm_we      (dm_we),
        .o_dm_addr    (dm_addr),
        .o_dm_wdata   (dm_wdata),
        .i_dm_rdata   (dm_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign dm_rdata = mem[dm_addr[7:2]];

    // Memory model: preload on request, otherwise commit writes at the end of the strobe cycle.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0000_0000;
            mem[4]  <= 32'h1122_3344;
            mem[63] <= 32'h8899_AABB;
        end else if (dm_we) begin
            mem[dm_addr[7:2]] <= dm_wdata;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int          got_lat;
        int          we_cnt;
        logic [31:0] wr_word;
        logic [31:0] rd;
        logic        er;
        got_lat = -1;
        we_cnt  = 0;
        wr_word = 32'hxxxx_xxxx;
        rd      = 32'hxxxx_xxxx;
        er      = 1'bx;
        @(negedge clk);
        check($sformatf("v%0d_ready_pre", idx), {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = v.we;
        req_size   = v.size;
        req_signed = v.sgn;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        @(posedge clk);
        #1;
        // Keep valid high with junk while busy: it must be ignored.
        req_we    = ~v.we;
        req_addr  = 32'h0000_0000;
        req_wdata = 32'h5A5A_5A5A;
        for (int k = 0; k < 8 && got_lat < 0; k++) begin
            @(negedge clk);
            if (k == 0) check($sformatf("v%0d_dm_addr", idx), dm_addr, {v.addr[31:2], 2'b00});
            if (dm_we) begin
                we_cnt++;
                wr_word = dm_wdata;
            end
            if (resp_valid) begin
                got_lat   = k;
                rd        = resp_rdata;
                er        = resp_err;
                req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        check($sformatf("v%0d_latency", idx), got_lat, v.lat);
        check($sformatf("v%0d_err", idx), {31'd0, er}, {31'd0, v.err});
        check($sformatf("v%0d_rdata", idx), rd, v.rdata);
        check($sformatf("v%0d_writes", idx), we_cnt, (v.we && !v.err) ? 1 : 0);
        if (v.we && !v.err) check($sformatf("v%0d_wr_word", idx), wr_word, v.mwdata);
        @(negedge clk);
        check($sformatf("v%0d_ready_post", idx), {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        int we_seen;
        int vld_seen;
        total      = 0;
        bad        = 0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        mem_init   = 1'b1;
        rst_n      = 1'b0;

        //                we    size   sgn   addr           wdata         lat err   rdata          mwdata
        vtab[0]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,        1, 1'b0, 32'h1122_3344, 32'h0};
        vtab[1]  = '{1'b1, 2'b00, 1'b0, 32'h0000_0011, 32'h0000_00AA, 2, 1'b0, 32'h0,        32'h11AA_3344};
        vtab[2]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,        1, 1'b0, 32'h11AA_3344, 32'h0};
        vtab[3]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0011, 32'h0,        1, 1'b0, 32'hFFFF_FFAA, 32'h0};
        vtab[4]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0011, 32'h0,        1, 1'b0, 32'h0000_00AA, 32'h0};
        vtab[5]  = '{1'b0, 2'b01, 1'b1, 32'h0000_0012, 32'h0,        1, 1'b0, 32'h0000_3344, 32'h0};
        vtab[6]  = '{1'b1, 2'b01, 1'b0, 32'h0000_0012, 32'h0000_BEEF, 2, 1'b0, 32'h0,        32'h11AA_BEEF};
        vtab[7]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,        1, 1'b0, 32'h11AA_BEEF, 32'h0};
`ifdef LSU_MISALIGN_TRAP_EN
        vtab[8]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0012, 32'h0,        0, 1'b1, 32'h0,        32'h0};
        vtab[19] = '{1'b0, 2'b01, 1'b0, 32'h0000_0011, 32'h0,        0, 1'b1, 32'h0,        32'h0};
`else
        vtab[8]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0012, 32'h0,        1, 1'b0, 32'h11AA_BEEF, 32'h0};
        vtab[19] = '{1'b0, 2'b01, 1'b0, 32'h0000_0011, 32'h0,        1, 1'b0, 32'h0000_11AA, 32'h0};
`endif
        vtab[9]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0,        0, 1'b1, 32'h0,        32'h0};
        vtab[10] = '{1'b0, 2'b11, 1'b0, 32'h0000_0010, 32'h0,        0, 1'b1, 32'h0,        32'h0};
        vtab[11] = '{1'b1, 2'b10, 1'b0, 32'h0000_0014, 32'hCAFE_F00D, 1, 1'b0, 32'h0,        32'hCAFE_F00D};
        vtab[12] = '{1'b0, 2'b01, 1'b1, 32'h0000_0014, 32'h0,        1, 1'b0, 32'hFFFF_CAFE, 32'h0};
        vtab[13] = '{1'b0, 2'b01, 1'b0, 32'h0000_0016, 32'h0,        1, 1'b0, 32'h0000_F00D, 32'h0};
        vtab[14] = '{1'b0, 2'b00, 1'b1, 32'h0000_0017, 32'h0,        1, 1'b0, 32'h0000_000D, 32'h0};
        vtab[15] = '{1'b0, 2'b00, 1'b0, 32'h0000_00FF, 32'h0,        1, 1'b0, 32'h0000_00BB, 32'h0};
        vtab[16] = '{1'b0, 2'b00, 1'b0, 32'hFFFF_FFFF, 32'h0,        0, 1'b1, 32'h0,        32'h0};
        vtab[17] = '{1'b1, 2'b11, 1'b0, 32'h0000_0010, 32'hFFFF_FFFF, 0, 1'b1, 32'h0,        32'h0};
        vtab[18] = '{1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 0, 1'b1, 32'h0,        32'h0};
        vtab[20] = '{1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,        1, 1'b0, 32'h11AA_BEEF, 32'h0};
        vtab[21] = '{1'b1, 2'b00, 1'b0, 32'h0000_0013, 32'h1234_5677, 2, 1'b0, 32'h0,        32'h11AA_BE77};
        vtab[22] = '{1'b0, 2'b10, 1'b1, 32'h0000_0010, 32'h0,        1, 1'b0, 32'h11AA_BE77, 32'h0};
        vtab[23] = '{1'b0, 2'b00, 1'b1, 32'h0000_0012, 32'h0,        1, 1'b0, 32'hFFFF_FFBE, 32'h0};
        vtab[24] = '{1'b0, 2'b10, 1'b0, 32'h0000_0000, 32'h0,        1, 1'b0, 32'h0000_0000, 32'h0};
        vtab[25] = '{1'b0, 2'b00, 1'b0, 32'h0000_00FC, 32'h0,        1, 1'b0, 32'h0000_0088, 32'h0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        mem_init = 1'b0;
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_err", {31'd0, resp_err}, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_dm_we", {31'd0, dm_we}, 32'd0);
        check("rst_dm_addr", dm_addr, 32'd0);
        check("rst_dm_wdata", dm_wdata, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) run_vec(i, vtab[i]);

        // Reset pulsed while a byte store sits in RD: aborted, no write, no response.
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'b00;
        req_addr  = 32'h0000_0010;
        req_wdata = 32'h0000_0055;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("abort_busy", {31'd0, req_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("abort_ready", {31'd0, req_ready}, 32'd1);
        check("abort_dm_we", {31'd0, dm_we}, 32'd0);
        check("abort_dm_addr", dm_addr, 32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        we_seen  = 0;
        vld_seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (dm_we) we_seen++;
            if (resp_valid) vld_seen++;
        end
        check("abort_no_write", we_seen, 0);
        check("abort_no_resp", vld_seen, 0);
        check("abort_mem", mem[4], 32'h11AA_BE77);
        run_vec(NV, vtab[22]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
